// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {instr, pc2} pairs.
// Presents NOP when empty, flushes on redirect, stops accepting after HALT.
module if_id_queue #(
  parameter int unsigned DEPTH   = 2,
  parameter logic [15:0] NOP     = 16'h0800,
  parameter logic [4:0]  HALT_OP = 5'b00000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                if_instr,
  input  logic [15:0]                if_pc2,
  input  logic                       if_valid,
  input  logic                       id_stall,
  input  logic                       flush,
  output logic [15:0]                id_instr,
  output logic [15:0]                id_pc2,
  output logic                       id_valid,
  output logic                       fetch_stall,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [15:0]   mem_instr [DEPTH];
  logic [15:0]   mem_pc2   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          halt_seen;
  logic          full;
  logic          push;
  logic          pop;
  logic          is_halt;

  assign full        = (cnt == CW'(DEPTH));
  assign fetch_stall = full | halt_seen;
  assign id_valid    = (cnt != '0);
  assign push        = if_valid & ~fetch_stall & ~flush;
  assign pop         = id_valid & ~id_stall & ~flush;
  assign is_halt     = (if_instr[15:11] == HALT_OP);
  assign count       = cnt;

  assign id_instr = id_valid ? mem_instr[rd_ptr] : NOP;
  assign id_pc2   = id_valid ? mem_pc2[rd_ptr]   : 16'h0000;

  // Storage holds stale data across reset/flush; only pointers matter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= if_instr;
      mem_pc2[wr_ptr]   <= if_pc2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      halt_seen <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      halt_seen <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (is_halt) halt_seen <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
